mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares one mem_system port (Addr/DataIn/Rd/Wr -> DataOut/Done/Stall/err) between the fetch
//  stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipeline.
//  A 3-state FSM issues one access at a time and holds the command until mem_done.
//  Data has priority; a streak counter bounds fetch starvation.
//  Per-requester done pulses and stall signals feed the hazard/freeze logic.
// PARAMETERS
//  MAX_DATA_STREAK  4  consecutive data grants allowed while i_req waits; then fetch is forced (>=1)
// PORTS
//  clk          in   1   clock
//  rst          in   1   asynchronous, active-high reset
//  i_req        in   1   fetch read request; held high until i_done or i_flush
//  i_addr       in   16  fetch address (PC); sampled at grant
//  i_flush      in   1   fetch request abandoned (branch taken); 1-cycle pulse
//  i_rdata      out  16  instruction word; valid only while i_done=1
//  i_done       out  1   fetch access complete (1-cycle pulse)
//  i_stall      out  1   fetch must hold its request this cycle
//  d_rd         in   1   data load request; held until d_done
//  d_wr         in   1   data store request; held until d_done
//  d_addr       in   16  data address; sampled at grant
//  d_wdata      in   16  store data; sampled at grant
//  d_rdata      out  16  load data; valid only while d_done=1
//  d_done       out  1   data access complete (1-cycle pulse)
//  d_stall      out  1   memory stage must freeze this cycle
//  mem_addr     out  16  to mem_system Addr
//  mem_datain   out  16  to mem_system DataIn
//  mem_rd       out  1   to mem_system Rd
//  mem_wr       out  1   to mem_system Wr
//  mem_dataout  in   16  from mem_system DataOut
//  mem_done     in   1   from mem_system Done
//  mem_stall    in   1   from mem_system Stall (informational; the FSM waits on mem_done)
//  mem_err      in   1   from mem_system err
//  err          out  1   registered; set on mem_err, or d_rd&d_wr sampled in IDLE; sticky until rst
// BEHAVIOUR
//  Reset (async): state=IDLE; addr/wdata latches=0; streak=0; drop_i=0; mem_rd=mem_wr=0;
//    i_done=d_done=0; err=0. Reset mid-access drops the command at once (mem_system shares rst).
//  States: IDLE, DBUSY, IBUSY.
//  IDLE: samples requests each cycle; no command is driven.
//    d_req=d_rd|d_wr. Go DBUSY if d_req & ~(i_req & streak==MAX_DATA_STREAK);
//    else go IBUSY if i_req & ~i_flush; else stay in IDLE.
//    On grant: latch addr/wdata and op (write wins if d_rd&d_wr; err set).
//  Grant latency: 1 cycle (request seen in IDLE -> command driven from the next cycle).
//  DBUSY/IBUSY: mem_addr/mem_datain/op are driven from latches; mem_rd or mem_wr is held high
//    up to and including the mem_done cycle. The cycle with mem_done=1 goes to IDLE.
//    The command is low in that IDLE cycle. Back-to-back accesses have one idle cycle between.
//  Done: d_done=mem_done&DBUSY. i_done=mem_done&IBUSY&~drop_i&~i_flush.
//    Both are combinational; d_rdata=i_rdata=mem_dataout.
//  i_flush during IBUSY: sets drop_i. The access still runs to mem_done, and no i_done is issued.
//    drop_i clears on leaving IBUSY. i_flush in IDLE blocks fetch grant that cycle only.
//  Streak: +1 (saturating at MAX_DATA_STREAK) on each DBUSY grant while i_req=1.
//    Cleared on any IBUSY grant or when i_req=0 in IDLE.
//  Stalls: d_stall=d_req&~d_done. i_stall=i_req&~i_done.
//    In the same cycle, d_done does not release i_stall.
//  mem_done in IDLE is ignored (no done pulse, no state change).
//  Addresses are passed unmodified (16-bit, no alignment check).
// TESTING
//  1. rst, then i_req=1, i_addr=0x0010, mem_done after 3 cycles.
//     -> mem_rd high for 3 cycles with mem_addr=0x0010; i_done for one cycle; i_rdata=mem_dataout.
//  2. i_req and d_wr (addr 0x0200, data 0xBEEF) both rise together.
//     -> DBUSY first: mem_wr=1, mem_datain=0xBEEF. After d_done, 1 idle cycle, then IBUSY.
//  3. MAX_DATA_STREAK=4, d_rd held continuously with i_req=1.
//     -> after 4 data grants the 5th grant is IBUSY; the streak resets to 0.
//  4. i_flush pulse in the 2nd IBUSY cycle.
//     -> mem_rd held until mem_done; i_done stays 0; FSM returns to IDLE.
//  5. rst asserted mid-DBUSY.
//     -> mem_rd/mem_wr drop in the same cycle; state=IDLE; d_done=0; streak=0.
//  6. d_rd=d_wr=1 in IDLE.
//     -> a write is issued and err=1 from the next cycle; err stays high until rst.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing a single mem_system port between the fetch and memory stages.
// One access at a time; data wins, but a streak counter bounds how long fetch can starve.
module mem_arbiter #(
  parameter int MAX_DATA_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        i_flush,
  output logic [15:0] i_rdata,
  output logic        i_done,
  output logic        i_stall,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_done,
  output logic        d_stall,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_datain,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [15:0] mem_dataout,
  input  logic        mem_done,
  input  logic        mem_stall,
  input  logic        mem_err,
  output logic        err
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);

  typedef enum logic [1:0] {IDLE, DBUSY, IBUSY} state_t;

  state_t        state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          wr_q, wr_d;
  logic          drop_i_q, drop_i_d;
  logic          err_q, err_d;
  logic [SW-1:0] streak_q, streak_d;

  logic d_req;
  logic streak_full;
  logic unused_mem_stall;

  assign d_req       = d_rd | d_wr;
  assign streak_full = (streak_q == SW'(MAX_DATA_STREAK));

  // The FSM only waits on mem_done, so the memory's own stall is not needed here.
  assign unused_mem_stall = mem_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
      drop_i_q <= 1'b0;
      err_q    <= 1'b0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_q     <= wr_d;
      drop_i_q <= drop_i_d;
      err_q    <= err_d;
      streak_q <= streak_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_d     = wr_q;
    drop_i_d = drop_i_q;
    streak_d = streak_q;
    err_d    = err_q | mem_err;

    case (state_q)
      IDLE: begin
        drop_i_d = 1'b0;
        if (d_rd && d_wr) err_d = 1'b1;
        if (!i_req) streak_d = '0;
        // Data is refused only when fetch is waiting and has already been passed over enough times.
        if (d_req && !(i_req && streak_full)) begin
          state_d = DBUSY;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          wr_d    = d_wr;
          if (i_req && !streak_full) streak_d = streak_q + SW'(1);
        end else if (i_req && !i_flush) begin
          state_d  = IBUSY;
          addr_d   = i_addr;
          wr_d     = 1'b0;
          streak_d = '0;
        end
      end
      DBUSY: begin
        if (mem_done) state_d = IDLE;
      end
      IBUSY: begin
        if (mem_done) begin
          state_d  = IDLE;
          drop_i_d = 1'b0;
        end else begin
          drop_i_d = drop_i_q | i_flush;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr   = addr_q;
  assign mem_datain = wdata_q;
  assign mem_rd     = ((state_q == DBUSY) && !wr_q) || (state_q == IBUSY);
  assign mem_wr     = (state_q == DBUSY) && wr_q;

  // A flushed fetch still completes on the memory side but must never be reported.
  assign d_done  = mem_done && (state_q == DBUSY);
  assign i_done  = mem_done && (state_q == IBUSY) && !drop_i_q && !i_flush;
  assign d_rdata = mem_dataout;
  assign i_rdata = mem_dataout;

  assign d_stall = d_req && !d_done;
  assign i_stall = i_req && !i_done;
  assign err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  localparam int MAX = 4;

  logic        clk, rst;
  logic        i_req, i_flush, i_done, i_stall;
  logic [15:0] i_addr, i_rdata;
  logic        d_rd, d_wr, d_done, d_stall;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic [15:0] mem_addr, mem_datain, mem_dataout;
  logic        mem_rd, mem_wr, mem_done, mem_stall, mem_err, err;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter #(.MAX_DATA_STREAK(MAX)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush), .i_rdata(i_rdata),
    .i_done(i_done), .i_stall(i_stall),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done), .d_stall(d_stall),
    .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_dataout(mem_dataout), .mem_done(mem_done), .mem_stall(mem_stall),
    .mem_err(mem_err), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    i_req = 0; i_addr = 0; i_flush = 0;
    d_rd = 0; d_wr = 0; d_addr = 0; d_wdata = 0;
    mem_dataout = 0; mem_done = 0; mem_stall = 0; mem_err = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    mem_done = 1;
    #1;
    n_cmp++; if ({mem_rd, mem_wr} !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_cmd: got %b want 00", {mem_rd, mem_wr}); end
    n_cmp++; if ({i_done, d_done} !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_done: got %b want 00", {i_done, d_done}); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_err: got %b want 0", err); end
    n_cmp++; if ({i_stall, d_stall} !== 2'b00) begin n_bad++; $display("[TB] FAIL reset_stall: got %b want 00", {i_stall, d_stall}); end
    @(negedge clk);
    rst = 0;
    mem_done = 0;
  endtask

  task automatic test_fetch();
    do_reset();
    i_req = 1; i_addr = 16'h0010;
    #1;
    n_cmp++; if (mem_rd !== 1'b0) begin n_bad++; $display("[TB] FAIL fetch_latency mem_rd: got %b want 0", mem_rd); end
    n_cmp++; if (i_stall !== 1'b1) begin n_bad++; $display("[TB] FAIL fetch_stall_idle: got %b want 1", i_stall); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      mem_done = (k == 2);
      mem_dataout = 16'h1234 + 16'(k);
      #1;
      n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0010) begin n_bad++; $display("[TB] FAIL fetch_cmd[%0d]: got rd=%b addr=%h want rd=1 addr=0010", k, mem_rd, mem_addr); end
      n_cmp++; if (i_done !== (k == 2)) begin n_bad++; $display("[TB] FAIL fetch_done[%0d]: got %b want %b", k, i_done, (k == 2)); end
      if (k == 2) begin
        n_cmp++; if (i_rdata !== 16'h1236 || i_stall !== 1'b0) begin n_bad++; $display("[TB] FAIL fetch_rdata: got %h stall=%b want 1236 stall=0", i_rdata, i_stall); end
      end
    end
    @(negedge clk);
    i_req = 0; mem_done = 0;
    #1;
    n_cmp++; if (mem_rd !== 1'b0 || i_done !== 1'b0) begin n_bad++; $display("[TB] FAIL fetch_after: got rd=%b done=%b want 0 0", mem_rd, i_done); end
  endtask

  task automatic test_priority();
    do_reset();
    i_req = 1; i_addr = 16'h0040;
    d_wr = 1; d_addr = 16'h0200; d_wdata = 16'hBEEF;
    #1;
    n_cmp++; if ({mem_rd, mem_wr} !== 2'b00) begin n_bad++; $display("[TB] FAIL prio_idle: got %b want 00", {mem_rd, mem_wr}); end
    @(negedge clk);
    mem_done = 1;
    #1;
    n_cmp++; if (mem_wr !== 1'b1 || mem_rd !== 1'b0) begin n_bad++; $display("[TB] FAIL prio_dcmd: got wr=%b rd=%b want 1 0", mem_wr, mem_rd); end
    n_cmp++; if (mem_addr !== 16'h0200 || mem_datain !== 16'hBEEF) begin n_bad++; $display("[TB] FAIL prio_daddr: got %h/%h want 0200/beef", mem_addr, mem_datain); end
    n_cmp++; if ({d_done, i_done, i_stall, d_stall} !== 4'b1010) begin n_bad++; $display("[TB] FAIL prio_done_stall: got %b want 1010", {d_done, i_done, i_stall, d_stall}); end
    @(negedge clk);
    d_wr = 0; mem_done = 0;
    #1;
    n_cmp++; if ({mem_rd, mem_wr} !== 2'b00) begin n_bad++; $display("[TB] FAIL prio_gap: got %b want 00", {mem_rd, mem_wr}); end
    @(negedge clk);
    mem_done = 1; mem_dataout = 16'hA5A5;
    #1;
    n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0040 || i_done !== 1'b1) begin n_bad++; $display("[TB] FAIL prio_fetch: got rd=%b addr=%h done=%b want 1 0040 1", mem_rd, mem_addr, i_done); end
    @(negedge clk);
    i_req = 0; mem_done = 0;
  endtask

  task automatic count_data_grants(input string tag);
    int dgrants = 0;
    bit seen = 0;
    for (int c = 0; c < 60 && !seen; c++) begin
      #1;
      if (d_done === 1'b1) dgrants++;
      if (i_done === 1'b1) seen = 1;
      @(negedge clk);
    end
    n_cmp++; if (!seen) begin n_bad++; $display("[TB] FAIL %s_timeout: got no i_done within 60 cycles want i_done", tag); end
    n_cmp++; if (dgrants != MAX) begin n_bad++; $display("[TB] FAIL %s_count: got %0d data grants want %0d", tag, dgrants, MAX); end
  endtask

  task automatic test_streak();
    do_reset();
    d_rd = 1; d_addr = 16'h0300; i_req = 1; i_addr = 16'h0080; mem_done = 1;
    count_data_grants("streak1");
    count_data_grants("streak2");
    clear_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    i_req = 1; i_addr = 16'h0100;
    #1;
    n_cmp++; if (mem_rd !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_idle: got %b want 0", mem_rd); end
    @(negedge clk);
    #1;
    n_cmp++; if (mem_rd !== 1'b1) begin n_bad++; $display("[TB] FAIL flush_busy1: got %b want 1", mem_rd); end
    @(negedge clk);
    i_flush = 1;
    #1;
    n_cmp++; if (mem_rd !== 1'b1 || i_done !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_pulse: got rd=%b done=%b want 1 0", mem_rd, i_done); end
    @(negedge clk);
    i_flush = 0; i_req = 0;
    #1;
    n_cmp++; if (mem_rd !== 1'b1) begin n_bad++; $display("[TB] FAIL flush_hold: got %b want 1", mem_rd); end
    @(negedge clk);
    mem_done = 1;
    #1;
    n_cmp++; if (mem_rd !== 1'b1 || i_done !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_nodone: got rd=%b done=%b want 1 0", mem_rd, i_done); end
    @(negedge clk);
    mem_done = 0; i_req = 1; i_addr = 16'h0104; i_flush = 1;
    #1;
    n_cmp++; if (mem_rd !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_back_idle: got %b want 0", mem_rd); end
    @(negedge clk);
    i_flush = 0;
    #1;
    n_cmp++; if (mem_rd !== 1'b0) begin n_bad++; $display("[TB] FAIL flush_blocks_grant: got %b want 0", mem_rd); end
    @(negedge clk);
    mem_done = 1;
    #1;
    n_cmp++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0104 || i_done !== 1'b1) begin n_bad++; $display("[TB] FAIL flush_refetch: got rd=%b addr=%h done=%b want 1 0104 1", mem_rd, mem_addr, i_done); end
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    d_rd = 1; d_addr = 16'h0500; i_req = 1; i_addr = 16'h0090;
    @(negedge clk);
    #1;
    n_cmp++; if (mem_rd !== 1'b1) begin n_bad++; $display("[TB] FAIL rstmid_busy: got %b want 1", mem_rd); end
    mem_done = 1; rst = 1;
    #1;
    n_cmp++; if ({mem_rd, mem_wr, d_done} !== 3'b000) begin n_bad++; $display("[TB] FAIL rstmid_drop: got %b want 000", {mem_rd, mem_wr, d_done}); end
    @(negedge clk);
    rst = 0;
    count_data_grants("rstmid_streak");
    clear_inputs();
  endtask

  task automatic test_err();
    do_reset();
    d_rd = 1; d_wr = 1; d_addr = 16'h0600; d_wdata = 16'h1357;
    #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("[TB] FAIL err_before: got %b want 0", err); end
    @(negedge clk);
    mem_done = 1;
    #1;
    n_cmp++; if ({mem_wr, mem_rd} !== 2'b10 || mem_datain !== 16'h1357) begin n_bad++; $display("[TB] FAIL err_write: got wr/rd=%b data=%h want 10 1357", {mem_wr, mem_rd}, mem_datain); end
    n_cmp++; if (err !== 1'b1 || d_done !== 1'b1) begin n_bad++; $display("[TB] FAIL err_set: got err=%b done=%b want 1 1", err, d_done); end
    @(negedge clk);
    d_rd = 0; d_wr = 0; mem_done = 0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("[TB] FAIL err_sticky: got %b want 1", err); end
    rst = 1;
    #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("[TB] FAIL err_clear: got %b want 0", err); end
    @(negedge clk);
    rst = 0; mem_err = 1;
    #1;
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("[TB] FAIL memerr_reg: got %b want 0", err); end
    @(negedge clk);
    mem_err = 0;
    #1;
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("[TB] FAIL memerr_set: got %b want 1", err); end
  endtask

  task automatic test_random();
    bit busy = 0, own_d = 0, cur_wr = 0, dropped = 0;
    int lat = 0, streak = 0;
    logic [15:0] cur_addr = 0, cur_data = 0;
    bit exp_rd, exp_wr, exp_dd, exp_id, exp_ds, exp_is;
    bit n_ireq, n_drd, n_dwr;
    logic [15:0] n_iaddr, n_daddr, n_wdata;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      i_flush = i_req && ($urandom_range(0, 7) == 0);
      mem_done = busy ? (lat == 0) : ($urandom_range(0, 5) == 0);
      mem_dataout = 16'($urandom);
      #1;
      exp_rd = busy && !cur_wr;
      exp_wr = busy && cur_wr;
      exp_dd = busy && own_d && mem_done;
      exp_id = busy && !own_d && mem_done && !dropped && !i_flush;
      exp_ds = (d_rd || d_wr) && !exp_dd;
      exp_is = i_req && !exp_id;
      n_cmp++; if (mem_rd !== exp_rd || mem_wr !== exp_wr) begin n_bad++; $display("[TB] FAIL rnd_cmd@%0d: got rd/wr=%b%b want %b%b", c, mem_rd, mem_wr, exp_rd, exp_wr); end
      n_cmp++; if (d_done !== exp_dd || i_done !== exp_id) begin n_bad++; $display("[TB] FAIL rnd_done@%0d: got d/i=%b%b want %b%b", c, d_done, i_done, exp_dd, exp_id); end
      n_cmp++; if (d_stall !== exp_ds || i_stall !== exp_is) begin n_bad++; $display("[TB] FAIL rnd_stall@%0d: got d/i=%b%b want %b%b", c, d_stall, i_stall, exp_ds, exp_is); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("[TB] FAIL rnd_err@%0d: got %b want 0", c, err); end
      if (busy) begin
        n_cmp++; if (mem_addr !== cur_addr) begin n_bad++; $display("[TB] FAIL rnd_addr@%0d: got %h want %h", c, mem_addr, cur_addr); end
      end
      if (busy && cur_wr) begin
        n_cmp++; if (mem_datain !== cur_data) begin n_bad++; $display("[TB] FAIL rnd_wdata@%0d: got %h want %h", c, mem_datain, cur_data); end
      end
      if (exp_dd) begin
        n_cmp++; if (d_rdata !== mem_dataout) begin n_bad++; $display("[TB] FAIL rnd_drdata@%0d: got %h want %h", c, d_rdata, mem_dataout); end
      end
      if (exp_id) begin
        n_cmp++; if (i_rdata !== mem_dataout) begin n_bad++; $display("[TB] FAIL rnd_irdata@%0d: got %h want %h", c, i_rdata, mem_dataout); end
      end
      // Model: one access in flight; otherwise pick the next owner from the arbitration rules.
      if (busy) begin
        if (!own_d && i_flush) dropped = 1;
        if (mem_done) begin busy = 0; dropped = 0; end
        else lat--;
      end else begin
        if (!i_req) streak = 0;
        if ((d_rd || d_wr) && !(i_req && streak == MAX)) begin
          busy = 1; own_d = 1; cur_addr = d_addr; cur_data = d_wdata; cur_wr = d_wr;
          if (i_req) streak = (streak + 1 > MAX) ? MAX : streak + 1;
          lat = $urandom_range(0, 3);
        end else if (i_req && !i_flush) begin
          busy = 1; own_d = 0; cur_addr = i_addr; cur_wr = 0; streak = 0;
          lat = $urandom_range(0, 3);
        end
      end
      n_drd = d_rd; n_dwr = d_wr; n_daddr = d_addr; n_wdata = d_wdata;
      if (exp_dd || !(d_rd || d_wr)) begin
        n_dwr = ($urandom_range(0, 1) == 1);
        n_drd = !n_dwr;
        if ($urandom_range(0, 3) == 0) begin n_drd = 0; n_dwr = 0; end
        n_daddr = 16'($urandom); n_wdata = 16'($urandom);
      end
      n_ireq = i_req; n_iaddr = i_addr;
      if (exp_id || i_flush || !i_req) begin
        n_ireq = ($urandom_range(0, 2) != 0);
        n_iaddr = 16'($urandom);
      end
      @(negedge clk);
      d_rd = n_drd; d_wr = n_dwr; d_addr = n_daddr; d_wdata = n_wdata;
      i_req = n_ireq; i_addr = n_iaddr;
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    @(negedge clk);
    test_reset();
    test_fetch();
    test_priority();
    test_streak();
    test_flush();
    test_reset_mid();
    test_random();
    test_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
